// File: rtl/dffrnq_sdpipe_pkg.sv
// Shared definitions for the dffrnq_sdpipe retiming register bank:
// scan-chain geometry helpers and the per-edge operating mode.
package dffrnq_sdpipe_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD    = 2'd0,
        MODE_CAPTURE = 2'd1,
        MODE_SHIFT   = 2'd2
    } stage_mode_e;

    function automatic int chain_len(input int width, input int depth);
        return depth * (width + 1);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Scan enable outranks the functional clock enable.
    function automatic stage_mode_e decode_mode(input logic se, input logic e);
        if (se)
            return MODE_SHIFT;
        else if (e)
            return MODE_CAPTURE;
        return MODE_HOLD;
    endfunction

endpackage

// File: rtl/dffrnq_sdpipe_stage.sv
// One pipeline stage: WIDTH data flops plus a valid flop, with a shared
// hold / capture / scan-shift mux and asynchronous active-low clear.
module dffrnq_sdpipe_stage
    import dffrnq_sdpipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RN,
    input  stage_mode_e      mode,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             cap_valid,
    input  logic             scan_in,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             scan_out
);

    // Scan order inside a stage is data bit0 .. bit WIDTH-1, then valid,
    // so {valid, data} shifts left by one with scan_in entering at bit 0.
    logic [WIDTH:0] chain;

    // NOTE: flops are written with <= so every stage samples the value its
    // neighbour held before the edge; = here would collapse the pipeline.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            chain <= {1'b0, RESET_VAL};
        end else begin
            case (mode)
                MODE_SHIFT:   chain <= {chain[WIDTH-1:0], scan_in};
                MODE_CAPTURE: chain <= {cap_valid, cap_data};
                default:      chain <= chain;
            endcase
        end
    end

    assign data     = chain[WIDTH-1:0];
    assign valid    = chain[WIDTH];
    assign scan_out = chain[WIDTH];

endmodule

// File: rtl/dffrnq_sdpipe.sv
// Parametrised multi-bit D-flop pipeline with per-stage valid tracking,
// optional bubble gating and a full mux-scan chain through every flop.
module dffrnq_sdpipe
    import dffrnq_sdpipe_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               DEPTH        = 3,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter bit               GATE_INVALID = 1'b0
) (
    input  logic                      CLK,
    input  logic                      RN,
    input  logic [WIDTH-1:0]          D,
    input  logic                      DV,
    input  logic                      E,
    input  logic                      SE,
    input  logic                      SI,
    output logic [WIDTH-1:0]          Q,
    output logic                      QV,
    output logic                      SO,
    output logic [cnt_w(DEPTH)-1:0]   CNT
);

    localparam int CNT_W = cnt_w(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             valid;
    } stage_t;

    stage_mode_e      mode;
    stage_t           cap    [DEPTH];
    logic             scan_i [DEPTH];
    logic             scan_o [DEPTH];
    logic [WIDTH-1:0] st_data [DEPTH];
    logic [DEPTH-1:0] st_valid;

    assign mode = decode_mode(SE, E);

    // Bubbles can be squashed to RESET_VAL so downstream logic never sees
    // stale data behind a cleared valid bit.
    assign cap[0].data  = (GATE_INVALID && !DV) ? RESET_VAL : D;
    assign cap[0].valid = DV;
    assign scan_i[0]    = SI;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign cap[k].data  = st_data[k-1];
            assign cap[k].valid = st_valid[k-1];
            assign scan_i[k]    = scan_o[k-1];
        end

        dffrnq_sdpipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .CLK       (CLK),
            .RN        (RN),
            .mode      (mode),
            .cap_data  (cap[k].data),
            .cap_valid (cap[k].valid),
            .scan_in   (scan_i[k]),
            .data      (st_data[k]),
            .valid     (st_valid[k]),
            .scan_out  (scan_o[k])
        );
    end

    // NOTE: the accumulator gets a value before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        CNT = '0;
        for (int k = 0; k < DEPTH; k++)
            CNT = CNT + CNT_W'(st_valid[k]);
    end

    assign Q  = st_data[DEPTH-1];
    assign QV = st_valid[DEPTH-1];
    assign SO = scan_o[DEPTH-1];

endmodule

// File: tb/tb_dffrnq_sdpipe.sv
// Self-checking bench for dffrnq_sdpipe: two instances (bubble gating off/on)
// share stimulus and are compared against an array-level reference model.
module tb_dffrnq_sdpipe;
    import dffrnq_sdpipe_pkg::*;

    localparam int W  = 8;
    localparam int DP = 3;
    localparam int L  = DP * (W + 1);

    logic         CLK, RN;
    logic [W-1:0] D;
    logic         DV, E, SE, SI;
    logic [W-1:0] q0, q1;
    logic         qv0, qv1, so0, so1;
    logic [1:0]   cnt0, cnt1;
    logic [11:0]  obs0, obs1;

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance stage arrays, index 0 = first stage.
    logic [W-1:0] md [2][DP];
    bit           mv [2][DP];

    assign obs0 = {q0, qv0, so0, cnt0};
    assign obs1 = {q1, qv1, so1, cnt1};

    dffrnq_sdpipe #(.WIDTH(W), .DEPTH(DP), .RESET_VAL(8'h00), .GATE_INVALID(1'b0)) u_dut (
        .CLK(CLK), .RN(RN), .D(D), .DV(DV), .E(E), .SE(SE), .SI(SI),
        .Q(q0), .QV(qv0), .SO(so0), .CNT(cnt0)
    );

    dffrnq_sdpipe #(.WIDTH(W), .DEPTH(DP), .RESET_VAL(8'h00), .GATE_INVALID(1'b1)) u_dut_g (
        .CLK(CLK), .RN(RN), .D(D), .DV(DV), .E(E), .SE(SE), .SI(SI),
        .Q(q1), .QV(qv1), .SO(so1), .CNT(cnt1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < DP; k++) begin
                md[g][k] = 8'h00;
                mv[g][k] = 1'b0;
            end
    endtask

    task automatic model_edge();
        bit flat [L];
        int p;
        for (int g = 0; g < 2; g++) begin
            if (SE) begin
                p = 0;
                for (int k = 0; k < DP; k++) begin
                    for (int b = 0; b < W; b++) begin
                        flat[p] = md[g][k][b];
                        p++;
                    end
                    flat[p] = mv[g][k];
                    p++;
                end
                for (int i = L - 1; i > 0; i--) flat[i] = flat[i-1];
                flat[0] = SI;
                p = 0;
                for (int k = 0; k < DP; k++) begin
                    for (int b = 0; b < W; b++) begin
                        md[g][k][b] = flat[p];
                        p++;
                    end
                    mv[g][k] = flat[p];
                    p++;
                end
            end else if (E) begin
                for (int k = DP - 1; k > 0; k--) begin
                    md[g][k] = md[g][k-1];
                    mv[g][k] = mv[g][k-1];
                end
                md[g][0] = (g == 1 && !DV) ? 8'h00 : D;
                mv[g][0] = DV;
            end
        end
    endtask

    function automatic logic [11:0] exp_vec(input int g);
        int c = 0;
        for (int k = 0; k < DP; k++) c += int'(mv[g][k]);
        return {md[g][DP-1], mv[g][DP-1], mv[g][DP-1], 2'(c)};
    endfunction

    // One active edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        if (RN) model_edge();
        #1;
    endtask

    task automatic do_reset();
        RN = 1'b0;
        model_reset();
        #1;
        RN = 1'b1;
        SE = 1'b0; E = 1'b0; DV = 1'b0; D = '0; SI = 1'b0;
    endtask

    task automatic test_reset();
        RN = 1'b0; SE = 1'b0; E = 1'b0; DV = 1'b0; D = '0; SI = 1'b0;
        model_reset();
        #3;
        checks++;
        if (obs0 !== 12'h000 || obs1 !== 12'h000) begin
            errors++;
            $display("FAIL reset_initial got %h/%h exp 000/000", obs0, obs1);
        end
        RN = 1'b1;
        E = 1'b1; DV = 1'b1; D = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (q0 !== 8'hFF || qv0 !== 1'b1 || cnt0 !== 2'd3) begin
            errors++;
            $display("FAIL reset_fill got q=%h qv=%b cnt=%0d exp q=ff qv=1 cnt=3", q0, qv0, cnt0);
        end
        #2;
        RN = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs0 !== 12'h000 || obs1 !== 12'h000) begin
            errors++;
            $display("FAIL reset_async got %h/%h exp 000/000", obs0, obs1);
        end
        RN = 1'b1;
        D = 8'h3C;
        step();
        checks++;
        if (cnt0 !== 2'd1 || q0 !== 8'h00 || obs0 !== exp_vec(0)) begin
            errors++;
            $display("FAIL reset_first_edge got %h exp %h (cnt 1)", obs0, exp_vec(0));
        end
        SE = 1'b1; SI = 1'b1;
        step();
        step();
        #2;
        RN = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs0 !== 12'h000 || obs1 !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_shift got %h/%h exp 000/000", obs0, obs1);
        end
        RN = 1'b1;
        SE = 1'b0; E = 1'b0; SI = 1'b0;
    endtask

    task automatic test_latency();
        logic [W-1:0] exp_q   [4] = '{8'h00, 8'h00, 8'hA5, 8'h00};
        logic         exp_qv  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]   exp_cnt [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        do_reset();
        E = 1'b1; DV = 1'b1; D = 8'hA5;
        for (int n = 0; n < 4; n++) begin
            step();
            DV = 1'b0; D = 8'h00;
            checks++;
            if (q0 !== exp_q[n] || qv0 !== exp_qv[n] || cnt0 !== exp_cnt[n] || obs0 !== exp_vec(0)) begin
                errors++;
                $display("FAIL latency_edge%0d got q=%h qv=%b cnt=%0d exp q=%h qv=%b cnt=%0d",
                         n + 1, q0, qv0, cnt0, exp_q[n], exp_qv[n], exp_cnt[n]);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [W-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        E = 1'b1; DV = 1'b1;
        for (int i = 0; i < 3; i++) begin
            D = vals[i];
            step();
        end
        E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            D = ~D;
            DV = ~DV;
            step();
            checks++;
            if (q0 !== 8'h11 || qv0 !== 1'b1 || cnt0 !== 2'd3 || obs1 !== exp_vec(1)) begin
                errors++;
                $display("FAIL hold_edge%0d got q=%h qv=%b cnt=%0d exp q=11 qv=1 cnt=3", i, q0, qv0, cnt0);
            end
        end
        E = 1'b1; DV = 1'b1; D = 8'h44;
        step();
        checks++;
        if (q0 !== 8'h22 || qv0 !== 1'b1) begin
            errors++;
            $display("FAIL hold_resume got q=%h qv=%b exp q=22 qv=1", q0, qv0);
        end
    endtask

    task automatic test_scan_order();
        logic exp_so;
        do_reset();
        SE = 1'b1; E = 1'b0; SI = 1'b1; DV = 1'b1; D = 8'hFF;
        for (int n = 1; n <= L + 1; n++) begin
            step();
            SI = 1'b0;
            exp_so = (n == L);
            checks++;
            if (so0 !== exp_so || so1 !== exp_so || obs0 !== exp_vec(0)) begin
                errors++;
                $display("FAIL scan_order_edge%0d got so=%b/%b exp %b", n, so0, so1, exp_so);
            end
        end
        SE = 1'b0;
    endtask

    task automatic test_scan_load();
        logic [W-1:0] tgt_d [DP] = '{8'h3C, 8'hC3, 8'h5A};
        bit           tgt_v [DP] = '{1'b0, 1'b1, 1'b1};
        bit           flat  [L];
        int           p = 0;
        for (int k = 0; k < DP; k++) begin
            for (int b = 0; b < W; b++) begin
                flat[p] = tgt_d[k][b];
                p++;
            end
            flat[p] = tgt_v[k];
            p++;
        end
        do_reset();
        SE = 1'b1; E = 1'b1; DV = 1'b0;
        for (int n = 1; n <= L; n++) begin
            SI = flat[L-n];
            D  = 8'($urandom);
            step();
        end
        SE = 1'b0; E = 1'b0; SI = 1'b0;
        step();
        checks++;
        if (q0 !== 8'h5A || qv0 !== 1'b1 || cnt0 !== 2'd2 || obs0 !== exp_vec(0)) begin
            errors++;
            $display("FAIL scan_load got q=%h qv=%b cnt=%0d exp q=5a qv=1 cnt=2", q0, qv0, cnt0);
        end
        checks++;
        if (q1 !== 8'h5A || qv1 !== 1'b1 || cnt1 !== 2'd2) begin
            errors++;
            $display("FAIL scan_load_gated got q=%h qv=%b cnt=%0d exp q=5a qv=1 cnt=2", q1, qv1, cnt1);
        end
    endtask

    task automatic test_bubble_gating();
        do_reset();
        E = 1'b1; DV = 1'b0; D = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (q0 !== 8'hFF || qv0 !== 1'b0) begin
            errors++;
            $display("FAIL gate_off got q=%h qv=%b exp q=ff qv=0", q0, qv0);
        end
        checks++;
        if (q1 !== 8'h00 || qv1 !== 1'b0) begin
            errors++;
            $display("FAIL gate_on got q=%h qv=%b exp q=00 qv=0", q1, qv1);
        end
        DV = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (q1 !== 8'hFF || qv1 !== 1'b1 || cnt1 !== 2'd3) begin
            errors++;
            $display("FAIL gate_on_valid got q=%h qv=%b cnt=%0d exp q=ff qv=1 cnt=3", q1, qv1, cnt1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            SE = ($urandom_range(0, 3) == 0);
            E  = ($urandom_range(0, 3) != 0);
            DV = 1'($urandom);
            SI = 1'($urandom);
            D  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                RN = 1'b0;
                model_reset();
                #1;
                RN = 1'b1;
            end else begin
                step();
            end
            checks++;
            if (obs0 !== exp_vec(0) || obs1 !== exp_vec(1)) begin
                errors++;
                $display("FAIL random_%0d got %h/%h exp %h/%h", n, obs0, obs1, exp_vec(0), exp_vec(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_enable_hold();
        test_scan_order();
        test_scan_load();
        test_bubble_gating();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dffrnq_sdpipe.md
Name: dffrnq_sdpipe

Overview:
- Parametrised multi-bit D-flip-flop pipeline: WIDTH-bit data, DEPTH stages, one valid bit per stage.
- Successor to the single-bit positive-edge D flop. Adds asynchronous active-low reset, clock enable, per-stage valid tracking, optional bubble gating and a full mux-scan chain.
- Used as a retiming/delay register bank in MCU datapaths built from this cell library.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 3, number of pipeline stages (>=1)
- RESET_VAL, 0, WIDTH-bit reset value for every data stage
- GATE_INVALID, 0, when 1, a stage-0 capture with DV=0 loads RESET_VAL instead of D

Ports:
- CLK  in  1  clock; positive edge active
- RN  in  1  reset; asynchronous, active-low
- D  in  WIDTH  functional data in
- DV  in  1  data-valid qualifier for D
- E  in  1  clock enable; functional mode only
- SE  in  1  scan enable; 1 = shift mode
- SI  in  1  scan data in
- Q  out  WIDTH  last-stage data
- QV  out  1  last-stage valid
- SO  out  1  scan data out = last-stage valid bit
- CNT  out  $clog2(DEPTH+1)  number of stages holding valid=1

Behaviour:
- Reset: RN=0 immediately, with no clock, forces all data stages to RESET_VAL and all valid bits to 0.
  - Outputs during reset: Q=RESET_VAL, QV=0, SO=0, CNT=0.
  - RN has top priority and is honoured mid-shift or mid-capture.
  - On RN deassertion, the first active CLK edge operates normally.
- Priority at posedge CLK with RN=1: SE over E.
- Shift mode (SE=1): shifts one position per edge regardless of E and DV.
  - Chain order: SI -> stage0 data bit0 .. bit WIDTH-1 -> stage0 valid -> stage1 data bit0 .. -> stage DEPTH-1 valid -> SO.
  - Chain length L = DEPTH*(WIDTH+1).
  - A bit presented at SI before edge n appears on SO after edge n+L-1.
- Capture mode (SE=0, E=1):
  - stage0.data <= (GATE_INVALID && !DV) ? RESET_VAL : D.
  - stage0.valid <= DV.
  - stage k <= stage k-1 for k = 1..DEPTH-1.
  - Latency: D/DV captured at edge n appear on Q/QV after edge n+DEPTH-1, i.e. DEPTH edges including the capture edge.
- Hold (SE=0, E=0): all stages hold; Q, QV and CNT are unchanged.
- Outputs:
  - Q and QV are driven directly from the last-stage flops; no combinational path from D or DV.
  - SO is driven directly from a flop.
  - CNT is the combinational popcount of the valid bits. It is always in 0..DEPTH and tracks scan-loaded valid bits as well.
- SE and E changes take effect at the next edge. There is no partial-edge behaviour.
- DEPTH=1: Q/QV follow the capture one edge later; L = WIDTH+1.

Decomposition:
- Shared package dffrnq_sdpipe_pkg:
  - function chain_len(WIDTH, DEPTH) = DEPTH*(WIDTH+1)
  - function cnt_w(DEPTH) = $clog2(DEPTH+1)
  - stage struct typedef {data, valid}, parametrised by WIDTH in the module
- Sub-module dffrnq_sdpipe_stage:
  - One stage: WIDTH data flops plus one valid flop.
  - Internal scan-vs-functional-vs-hold mux and async RN clear.
  - Ports: scan_in and scan_out.
- The top level instantiates DEPTH stages via generate, stitches the scan chain, and computes CNT.

Test Plan:
(WIDTH=8, DEPTH=3, RESET_VAL=0 unless stated.)
- Async reset: set state to 0xFF/valid in all stages, drop RN between clock edges -> Q=0x00, QV=0, SO=0, CNT=0 with no CLK edge; first edge after RN=1 captures normally.
- Latency: E=1, SE=0, DV=1, D=0xA5 at edge 1, then DV=0 -> Q=0xA5 and QV=1 after edge 3; CNT=1 after edges 1, 2, 3; QV=0 and CNT=0 after edge 4.
- Enable hold: capture 0x11, 0x22, 0x33 with DV=1, then E=0 for 5 edges with D toggling -> Q=0x11, QV=1, CNT=3 held; E=1 resumes with Q=0x22 after the next edge.
- Scan length/order: SE=1, SI=1 for one edge then 0 -> SO=0 through edge 26, SO=1 after edge 27, SO=0 after edge 28; SE=1 with E=0 still shifts.
- Scan load/unload: shift in 27 bits giving stage2={0x5A, v=1} -> with SE=0, Q=0x5A, QV=1, CNT matches the loaded valid count.
- Bubble gating: D=0xFF, DV=0 captured -> GATE_INVALID=0 gives Q=0xFF, QV=0 after edge 3; GATE_INVALID=1 gives Q=0x00, QV=0.
